// File: rtl/emd_stop_ctrl.sv
// EMD stop controller: counts strict local extrema of a residue frame and decides between another sifting pass and decomposition done.
// Optional build macro STOP_ENERGY_EN adds a sum|Rin| energy stop criterion.
module emd_stop_ctrl #(
    parameter int FRAME_LEN  = 1024,
    parameter int MIN_EXT    = 2,
    parameter int MAX_IMF    = 8,
    parameter int ENERGY_THR = 64
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               follow_start,
    input  logic signed [15:0] Rin,
    output logic               next_start,
    output logic               emd_done,
    output logic [3:0]         imf_count,
    output logic [15:0]        ext_count,
    output logic               busy
);

    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DECIDE
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic signed [15:0] r_s1;
    logic signed [15:0] r_s2;
    logic [15:0]        r_ext_cnt;
    logic               r_done_seen;

    logic [IDX_W-1:0]   w_idx_inc;
    logic               w_is_ext;
    logic [15:0]        w_ext_inc;
    logic [3:0]         w_n;
    logic               w_energy_low;
    logic               w_stop;
    logic               w_start;

    // r_s1 is the candidate middle sample, r_s2 its left neighbour, Rin its right neighbour
    assign w_is_ext  = ((r_s1 > r_s2) && (r_s1 > Rin)) || ((r_s1 < r_s2) && (r_s1 < Rin));
    assign w_idx_inc = r_idx + 1'b1;
    assign w_ext_inc = (r_ext_cnt == 16'hFFFF) ? r_ext_cnt : r_ext_cnt + 16'd1;
    assign w_n       = (imf_count == 4'hF) ? imf_count : imf_count + 4'd1;
    assign w_start   = follow_start && (r_state != S_DECIDE);

`ifdef STOP_ENERGY_EN
    localparam int ACC_W = 16 + IDX_W;

    logic [ACC_W-1:0] r_acc;
    logic [16:0]      w_rin_ext;
    logic [16:0]      w_abs;

    assign w_rin_ext    = {Rin[15], Rin};
    assign w_abs        = Rin[15] ? (~w_rin_ext + 17'd1) : w_rin_ext;
    assign w_energy_low = r_acc < ACC_W'(ENERGY_THR);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_acc <= '0;
        end else if (w_start) begin
            r_acc <= ACC_W'(w_abs);
        end else if (r_state == S_COLLECT) begin
            r_acc <= r_acc + ACC_W'(w_abs);
        end
    end
`else
    assign w_energy_low = 1'b0;
`endif

    assign w_stop = (r_ext_cnt < 16'(MIN_EXT)) || (w_n >= 4'(MAX_IMF)) || w_energy_low;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_s1        <= '0;
            r_s2        <= '0;
            r_ext_cnt   <= '0;
            r_done_seen <= 1'b0;
            next_start  <= 1'b0;
            emd_done    <= 1'b0;
            imf_count   <= '0;
            ext_count   <= '0;
            busy        <= 1'b0;
        end else begin
            next_start <= 1'b0;
            emd_done   <= 1'b0;
            if (w_start) begin
                // Fresh start or abort: this sample becomes sample 0 of a new frame
                r_state     <= S_COLLECT;
                busy        <= 1'b1;
                r_idx       <= '0;
                r_s1        <= Rin;
                r_s2        <= '0;
                r_ext_cnt   <= '0;
                r_done_seen <= 1'b0;
                if (r_done_seen) begin
                    imf_count <= '0;
                end
            end else begin
                case (r_state)
                    S_COLLECT: begin
                        r_idx <= w_idx_inc;
                        r_s2  <= r_s1;
                        r_s1  <= Rin;
                        if ((r_idx != '0) && w_is_ext) begin
                            r_ext_cnt <= w_ext_inc;
                        end
                        if (w_idx_inc == IDX_W'(FRAME_LEN - 1)) begin
                            r_state <= S_DECIDE;
                        end
                    end
                    S_DECIDE: begin
                        r_state   <= S_IDLE;
                        busy      <= 1'b0;
                        imf_count <= w_n;
                        ext_count <= r_ext_cnt;
                        if (w_stop) begin
                            emd_done    <= 1'b1;
                            r_done_seen <= 1'b1;
                        end else begin
                            next_start <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_emd_stop_ctrl.sv
// Scoreboard bench for emd_stop_ctrl with FRAME_LEN=8, MIN_EXT=2, MAX_IMF=3, ENERGY_THR=64.
module tb_emd_stop_ctrl;

    localparam int FL = 8;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic               follow_start = 1'b0;
    logic signed [15:0] Rin = '0;
    logic               next_start;
    logic               emd_done;
    logic [3:0]         imf_count;
    logic [15:0]        ext_count;
    logic               busy;

    emd_stop_ctrl #(
        .FRAME_LEN (FL),
        .MIN_EXT   (2),
        .MAX_IMF   (3),
        .ENERGY_THR(64)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .follow_start(follow_start),
        .Rin         (Rin),
        .next_start  (next_start),
        .emd_done    (emd_done),
        .imf_count   (imf_count),
        .ext_count   (ext_count),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        bit done;
        int at;
        int imf;
        int ext;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: every pulse must match the oldest expected decision
    always @(negedge CLK) begin
        if (next_start || emd_done) begin
            check("pulse_exclusive", int'(next_start & emd_done), 0);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got next_start=%0d emd_done=%0d at cycle %0d, expected no pulse",
                         next_start, emd_done, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_kind_done", int'(emd_done), int'(e.done));
                check("pulse_cycle", cyc, e.at);
                check("imf_count", int'(imf_count), e.imf);
                check("ext_count", int'(ext_count), e.ext);
                $display("decision at cycle %0d: next_start=%0d emd_done=%0d imf=%0d ext=%0d",
                         cyc, next_start, emd_done, imf_count, ext_count);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic drive_frame(input logic [FL-1:0][15:0] f, input int n, input bit push,
                               input bit e_done, input int e_imf, input int e_ext);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
            follow_start = (i == 0);
            Rin          = f[i];
            if (i == 0 && push) begin
                exp_t e;
                e.done = e_done;
                e.at   = cyc + 9;
                e.imf  = e_imf;
                e.ext  = e_ext;
                sb.push_back(e);
            end
            if (i == 2) check("busy_collect", int'(busy), 1);
        end
        if (n == FL) begin
            @(posedge CLK);
            #1;
            follow_start = 1'b0;
            Rin          = '0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_next_start"}, int'(next_start), 0);
        check({tag, "_emd_done"}, int'(emd_done), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_imf_count"}, int'(imf_count), 0);
        check({tag, "_ext_count"}, int'(ext_count), 0);
    endtask

    logic [FL-1:0][15:0] ramp, osc, plat, alt3, sramp;

    initial begin
        for (int i = 0; i < FL; i++) begin
            ramp[i]  = 16'(i);
            osc[i]   = (i % 2 == 1) ? 16'd100 : 16'd0;
            plat[i]  = 16'd0;
            alt3[i]  = (i % 2 == 1) ? 16'hFFFD : 16'd3;
            sramp[i] = 16'(i - 3);
        end
        plat[1] = 16'd5;
        plat[2] = 16'd5;

        repeat (3) @(posedge CLK);
        #1;
        check_all_zero("reset");
        RST = 1'b0;
        idle(2);

        $display("frame: ramp 0..7");
        drive_frame(ramp, FL, 1'b1, 1'b1, 1, 0);
        idle(4);
        check("busy_idle", int'(busy), 0);

        $display("frame: oscillating 0/100");
        drive_frame(osc, FL, 1'b1, 1'b0, 1, 6);
        idle(4);

        $display("frame: reset at sample 5");
        drive_frame(osc, 5, 1'b0, 1'b0, 0, 0);
        @(posedge CLK);
        #1;
        follow_start = 1'b0;
        Rin          = osc[5];
        RST          = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check_all_zero("midreset");
        idle(12);

        $display("frames: three oscillating back-to-back");
        drive_frame(osc, FL, 1'b1, 1'b0, 1, 6);
        idle(4);
        drive_frame(osc, FL, 1'b1, 1'b0, 2, 6);
        idle(4);
        drive_frame(osc, FL, 1'b1, 1'b1, 3, 6);
        idle(4);
        check("imf_hold_after_done", int'(imf_count), 3);

        $display("frame: abort at sample 4 then restart");
        drive_frame(osc, 4, 1'b0, 1'b0, 0, 0);
        check("imf_clear_on_start", int'(imf_count), 0);
        drive_frame(osc, FL, 1'b1, 1'b0, 1, 6);
        idle(4);

        $display("frame: plateau 0,5,5,0,...");
        drive_frame(plat, FL, 1'b1, 1'b1, 2, 0);
        idle(4);

        $display("frame: alternating +/-3");
`ifdef STOP_ENERGY_EN
        drive_frame(alt3, FL, 1'b1, 1'b1, 1, 6);
`else
        drive_frame(alt3, FL, 1'b1, 1'b0, 1, 6);
`endif
        idle(4);

        $display("frame: signed ramp -3..4");
`ifdef STOP_ENERGY_EN
        drive_frame(sramp, FL, 1'b1, 1'b1, 1, 0);
`else
        drive_frame(sramp, FL, 1'b1, 1'b1, 2, 0);
`endif
        idle(6);

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
